// File: rtl/simon_seq.sv
// Simon-game sequencer: grows an LFSR-driven colour sequence, plays it back, checks the replay.
// Optional input timeout is built when SIMON_TIMEOUT_EN is defined.
module simon_seq #(
    parameter int          COLOR_W        = 2,
    parameter int          MAX_LEN        = 16,
    parameter int          SHOW_CYCLES    = 4,
    parameter int          GAP_CYCLES     = 2,
    parameter logic [15:0] SEED           = 16'hACE1,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             in_valid,
    input  logic [COLOR_W-1:0]               in,
    output logic [COLOR_W-1:0]               out,
    output logic                             out_valid,
    output logic                             awaiting,
    output logic [$clog2(MAX_LEN+1)-1:0]     level,
    output logic                             win,
    output logic                             lose
);

    localparam int LW    = $clog2(MAX_LEN + 1);
    localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TMAX  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int TW    = $clog2(TMAX + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EXTEND  = 3'd1;
    localparam logic [2:0] S_SHOW    = 3'd2;
    localparam logic [2:0] S_GAP     = 3'd3;
    localparam logic [2:0] S_WAIT_IN = 3'd4;
    localparam logic [2:0] S_WIN     = 3'd5;
    localparam logic [2:0] S_LOSE    = 3'd6;

    logic [2:0]         state_reg, state_next;
    logic [15:0]        lfsr_reg, lfsr_next;
    logic [LW-1:0]      len_reg, len_next;
    logic [LW-1:0]      idx_reg, idx_next;
    logic [TW-1:0]      timer_reg, timer_next;

    logic [COLOR_W-1:0] mem [MAX_LEN];
    logic [15:0]        lfsr_step;
    logic [COLOR_W-1:0] mem_rd;
    logic               last_idx;

`ifdef SIMON_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tcount_reg, tcount_next;
`endif

    assign lfsr_step = {lfsr_reg[14:0],
                        lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    assign mem_rd    = mem[idx_reg[AW-1:0]];
    assign last_idx  = (idx_reg == len_reg - LW'(1));

    // Sequence storage is deliberately left out of reset so it maps onto RAM.
    always_ff @(posedge clock) begin
        if (state_reg == S_EXTEND) begin
            mem[len_reg[AW-1:0]] <= lfsr_step[COLOR_W-1:0];
        end
    end

    always_comb begin
        state_next = state_reg;
        lfsr_next  = lfsr_reg;
        len_next   = len_reg;
        idx_next   = idx_reg;
        timer_next = timer_reg;
`ifdef SIMON_TIMEOUT_EN
        tcount_next = tcount_reg;
`endif
        case (state_reg)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start) begin
                    len_next   = '0;
                    state_next = S_EXTEND;
                end
            end
            S_EXTEND: begin
                lfsr_next  = lfsr_step;
                len_next   = len_reg + LW'(1);
                idx_next   = '0;
                timer_next = '0;
                state_next = S_SHOW;
            end
            S_SHOW: begin
                if (timer_reg == TW'(SHOW_CYCLES - 1)) begin
                    timer_next = '0;
                    state_next = S_GAP;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            S_GAP: begin
                if (timer_reg == TW'(GAP_CYCLES - 1)) begin
                    timer_next = '0;
                    if (last_idx) begin
                        idx_next   = '0;
                        state_next = S_WAIT_IN;
`ifdef SIMON_TIMEOUT_EN
                        tcount_next = '0;
`endif
                    end else begin
                        idx_next   = idx_reg + LW'(1);
                        state_next = S_SHOW;
                    end
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            S_WAIT_IN: begin
                // A press always wins over a timeout expiring in the same cycle.
                if (in_valid) begin
`ifdef SIMON_TIMEOUT_EN
                    tcount_next = '0;
`endif
                    if (in != mem_rd) begin
                        state_next = S_LOSE;
                    end else if (!last_idx) begin
                        idx_next = idx_reg + LW'(1);
                    end else if (len_reg == LW'(MAX_LEN)) begin
                        state_next = S_WIN;
                    end else begin
                        state_next = S_EXTEND;
                    end
                end
`ifdef SIMON_TIMEOUT_EN
                else if (tcount_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_next = S_LOSE;
                end else begin
                    tcount_next = tcount_reg + CW'(1);
                end
`endif
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
            lfsr_reg  <= SEED;
            len_reg   <= '0;
            idx_reg   <= '0;
            timer_reg <= '0;
`ifdef SIMON_TIMEOUT_EN
            tcount_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            lfsr_reg  <= lfsr_next;
            len_reg   <= len_next;
            idx_reg   <= idx_next;
            timer_reg <= timer_next;
`ifdef SIMON_TIMEOUT_EN
            tcount_reg <= tcount_next;
`endif
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    assign out_valid = (state_reg == S_SHOW);
    assign out       = out_valid ? mem_rd : '0;
    assign awaiting  = (state_reg == S_WAIT_IN);
    assign win       = (state_reg == S_WIN);
    assign lose      = (state_reg == S_LOSE);
    assign level     = len_reg;

endmodule

// File: tb/tb_simon_seq.sv
// Directed bench for simon_seq (MAX_LEN=2): LFSR model feeds a scoreboard queue checked during playback.
module tb_simon_seq;

    logic       clock;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic [1:0] din;
    logic [1:0] dout;
    logic       out_valid;
    logic       awaiting;
    logic [1:0] level;
    logic       win;
    logic       lose;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_lfsr;
    logic [1:0]  seq [$];
    logic [1:0]  exp_q [$];

    simon_seq #(
        .COLOR_W(2),
        .MAX_LEN(2),
        .SHOW_CYCLES(4),
        .GAP_CYCLES(2),
        .SEED(16'hACE1),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in(din),
        .out(dout),
        .out_valid(out_valid),
        .awaiting(awaiting),
        .level(level),
        .win(win),
        .lose(lose)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {24'd0, dout, out_valid, awaiting, level, win, lose}, 32'd0);
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Model of one EXTEND: append a colour and queue the whole round's expected playback.
    task automatic model_extend();
        m_lfsr = lfsr_adv(m_lfsr);
        seq.push_back(m_lfsr[1:0]);
        foreach (seq[k]) exp_q.push_back(seq[k]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic press(input logic [1:0] c);
        in_valid = 1'b1;
        din      = c;
        @(negedge clock);
        in_valid = 1'b0;
        $display("press colour=%0d -> awaiting=%0b win=%0b lose=%0b level=%0d",
                 c, awaiting, win, lose, level);
    endtask

    // Entered at the negedge where the DUT sits in EXTEND.
    task automatic playback(input int abort_at, input bit inject);
        logic [1:0] want;
        check("extend_out_valid", {31'd0, out_valid}, 32'd0);
        check("extend_awaiting", {31'd0, awaiting}, 32'd0);
        model_extend();
        for (int i = 0; i < seq.size(); i++) begin
            want = exp_q.pop_front();
            for (int c = 0; c < 4; c++) begin
                @(negedge clock);
                if (inject && i == 0 && c == 1) begin
                    in_valid = 1'b0;
                    start    = 1'b0;
                end
                check("show_out_valid", {31'd0, out_valid}, 32'd1);
                check("show_out", {30'd0, dout}, {30'd0, want});
                check("show_level", {30'd0, level}, seq.size());
                check("show_flags", {29'd0, awaiting, win, lose}, 32'd0);
                if (inject && i == 0 && c == 0) begin
                    in_valid = 1'b1;
                    din      = ~want;
                    start    = 1'b1;
                end
            end
            for (int g = 0; g < 2; g++) begin
                @(negedge clock);
                check("gap_dark", {29'd0, dout, out_valid}, 32'd0);
                check("gap_awaiting", {31'd0, awaiting}, 32'd0);
                if (abort_at == i && g == 0) return;
            end
        end
        @(negedge clock);
        check("awaiting_after_play", {31'd0, awaiting}, 32'd1);
        check("level_after_play", {30'd0, level}, seq.size());
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("round len=%0d played, awaiting=%0b", seq.size(), awaiting);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        din      = 2'b00;
        m_lfsr   = 16'hACE1;
        repeat (3) @(negedge clock);
        check_all_zero("in_reset");
        reset = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            check_all_zero("idle_no_start");
        end
        $display("idle 50 cycles after reset release");

        // Game 1: two rounds, then a wrong press in round 2.
        pulse_start();
        check("g1_extend_level", {30'd0, level}, 32'd0);
        playback(-1, 1'b0);
        press(seq[0]);
        playback(-1, 1'b0);
        press(seq[0]);
        check("g1_mid_awaiting", {31'd0, awaiting}, 32'd1);
        check("g1_mid_lose", {31'd0, lose}, 32'd0);
        press(~seq[1]);
        check("g1_lose", {31'd0, lose}, 32'd1);
        check("g1_lose_awaiting", {31'd0, awaiting}, 32'd0);
        check("g1_lose_win", {31'd0, win}, 32'd0);
        for (int n = 0; n < 3; n++) begin
            in_valid = 1'b1;
            din      = seq[0];
            @(negedge clock);
            in_valid = 1'b0;
            check("g1_lose_held", {31'd0, lose}, 32'd1);
            check("g1_lose_level", {30'd0, level}, 32'd2);
        end

        // Game 2: LFSR continues, full correct replay wins.
        seq.delete();
        pulse_start();
        check("g2_extend_lose_cleared", {31'd0, lose}, 32'd0);
        check("g2_extend_level", {30'd0, level}, 32'd0);
        playback(-1, 1'b0);
        press(seq[0]);
        playback(-1, 1'b0);
        press(seq[0]);
        press(seq[1]);
        check("g2_win", {31'd0, win}, 32'd1);
        check("g2_win_flags", {30'd0, awaiting, lose}, 32'd0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            check("g2_win_held", {31'd0, win}, 32'd1);
            check("g2_win_dark", {31'd0, out_valid}, 32'd0);
            check("g2_win_level", {30'd0, level}, 32'd2);
        end

        // Game 3: press/start during SHOW are ignored, then reset lands mid-GAP.
        seq.delete();
        pulse_start();
        check("g3_win_cleared", {31'd0, win}, 32'd0);
        playback(-1, 1'b1);
        press(seq[0]);
        playback(0, 1'b0);
        reset = 1'b0;
        #1;
        check_all_zero("async_reset_same_cycle");
        @(negedge clock);
        check_all_zero("reset_held");
        reset = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clock);
            check_all_zero("idle_after_reset");
        end
        $display("reset mid-gap aborted the game");

        // After reset the LFSR is back at SEED, so the first colour repeats game 1.
        m_lfsr = 16'hACE1;
        seq.delete();
        exp_q.delete();
        pulse_start();
        playback(-1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simon_seq.md
Name: simon_seq

Overview:
- Parametrised Simon-game sequencer; successor to the fixed 2-bit Simon block.
- Grows a pseudo-random colour sequence one entry per round and plays it back on out/out_valid with programmable on/gap timing.
- Checks the player's replay on in/in_valid and reports win or lose.
- Sits between the player input debouncer and the LED/tone driver.

Parameters:
- COLOR_W, 2, colour width in bits (2^COLOR_W colours).
- MAX_LEN, 16, sequence length needed to win (1..256).
- SHOW_CYCLES, 4, cycles each colour is presented (>=1).
- GAP_CYCLES, 2, dark cycles after each presented colour (>=1).
- SEED, 16'hACE1, LFSR reset value (must be nonzero).
- TIMEOUT_CYCLES, 64, input timeout; used only with SIMON_TIMEOUT_EN.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts a new game from IDLE, WIN or LOSE.
- in_valid  in  1  player press strobe, one cycle per press.
- in  in  COLOR_W  colour pressed; qualified by in_valid.
- out  out  COLOR_W  colour being presented; 0 when out_valid=0.
- out_valid  out  1  high while a colour is presented.
- awaiting  out  1  high in WAIT_IN.
- level  out  $clog2(MAX_LEN+1)  current sequence length.
- win  out  1  high in WIN state.
- lose  out  1  high in LOSE state.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, lfsr=SEED, len=0, idx=0, timer=0.
  - All outputs 0.
  - Sequence RAM (MAX_LEN x COLOR_W) is not cleared.
- States: IDLE, EXTEND, SHOW, GAP, WAIT_IN, WIN, LOSE.
- IDLE/WIN/LOSE:
  - start=1 → len=0, go to EXTEND next cycle.
  - start in any other state is ignored.
  - WIN and LOSE hold their flag until start or reset.
- LFSR: 16-bit, advances only in EXTEND.
  - fb = l[15]^l[13]^l[12]^l[10]; l <= {l[14:0], fb}.
  - The appended colour is the new l[COLOR_W-1:0].
  - The LFSR is not reseeded by start, so successive games differ.
- EXTEND (exactly 1 cycle): mem[len] <= colour; len <= len+1; idx <= 0; go to SHOW.
- SHOW: out=mem[idx], out_valid=1 for exactly SHOW_CYCLES cycles, then GAP.
- GAP: out=0, out_valid=0 for exactly GAP_CYCLES cycles.
  - If idx==len-1: idx <= 0, go to WAIT_IN.
  - Else: idx <= idx+1, go to SHOW.
- level updates in the cycle after EXTEND and stays stable for the rest of the round.
- WAIT_IN: awaiting=1; each in_valid compares in against mem[idx].
  - Mismatch → LOSE.
  - Match with idx<len-1 → idx+1, stay in WAIT_IN.
  - Match with idx==len-1 and len==MAX_LEN → WIN.
  - Match with idx==len-1 and len<MAX_LEN → EXTEND.
  - Evaluation is registered: the state changes on the clock edge that samples in_valid.
- in_valid outside WAIT_IN is ignored; presses during playback are not queued.
- win, lose and awaiting are one-hot with each other.
- out_valid is never high together with win, lose or awaiting.
- Reset during any state aborts immediately to the reset values above.

Optional Feature:
- Macro SIMON_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT_IN and on every accepted in_valid.
  - If it reaches TIMEOUT_CYCLES with no press → LOSE.
  - A press in the same cycle the count is reached takes priority over the timeout.
- Undefined: no counter is built; WAIT_IN waits indefinitely.

Test Plan:
- Reset release, no start for 50 cycles → out=0, out_valid=0, level=0, win=0, lose=0, awaiting=0 throughout.
- Defaults, start pulse → EXTEND, then out_valid high for 4 cycles with out=2'b11 (LFSR 16'hACE1→16'h59C3), then 2 dark cycles, then awaiting=1, level=1.
- Round 1: press in=2'b11 → round 2 plays 2'b11, 2'b11 (LFSR 16'h59C3→16'hB387) for 12 cycles total, level=2. Press 2'b11 then 2'b00 → lose=1 one cycle after the second press, awaiting=0.
- MAX_LEN=2, correct replay of both rounds → win=1 after the final press; stays high; start → win=0, level=1, new playback begins.
- Pulse in_valid and start during SHOW, and reset low mid-GAP → press/start ignored; reset forces all outputs to 0 within the same cycle.
- With SIMON_TIMEOUT_EN, TIMEOUT_CYCLES=8:
  - No press for 8 cycles in WAIT_IN → lose=1.
  - Press at cycle 7 → no lose, counter restarts.
